time_alarm_core: RTL

Holds the running time of day (hours, minutes, seconds) and the alarm setpoint (hours, minutes) for the alarm clock. It sits directly downstream of the mode state machine. It consumes that machine's `adjust` flag, the one-hot-style `EN` mode vector, and the debounced `up`/`down` pulses. It returns `secs` and the alarm-match flag `Z` to the state machine and drives all digit values to the display path.

---
 rtl/clock_pkg.sv | 39 +++
 rtl/time_alarm_core_if.sv | 27 ++
 rtl/mod_field_counter.sv | 47 ++++
 rtl/time_alarm_core.sv | 94 +++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants and edit-target decoding for the alarm clock time/alarm datapath.
package clock_pkg;

    // Field moduli
    localparam int HOURS_MOD = 24;
    localparam int MINS_MOD  = 60;
    localparam int SECS_MOD  = 60;

    // Field widths
    localparam int HH_W = 5;
    localparam int MM_W = 6;

    // Bit positions inside the EN mode vector
    localparam int EN_TH = 4;
    localparam int EN_TM = 3;
    localparam int EN_AH = 2;
    localparam int EN_AM = 1;

    // Which field an adjust-mode edit targets
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TH,
        SEL_TM,
        SEL_AH,
        SEL_AM
    } edit_sel_e;

    // Priority pick of the edit target: time hours > time minutes > alarm hours > alarm minutes.
    function automatic edit_sel_e decode_sel(input logic [4:1] en);
        edit_sel_e sel;
        sel = SEL_NONE;
        if (en[EN_TH])      sel = SEL_TH;
        else if (en[EN_TM]) sel = SEL_TM;
        else if (en[EN_AH]) sel = SEL_AH;
        else if (en[EN_AM]) sel = SEL_AM;
        return sel;
    endfunction

endpackage

// File: rtl/time_alarm_core_if.sv
// Bundle between the mode state machine (master) and the time/alarm core (slave).
interface time_alarm_core_if;
    import clock_pkg::*;

    logic            tick_1hz;
    logic            adjust;
    logic [4:0]      EN;
    logic            up;
    logic            down;
    logic [HH_W-1:0] time_hh;
    logic [MM_W-1:0] time_mm;
    logic [MM_W-1:0] secs;
    logic [HH_W-1:0] alarm_hh;
    logic [MM_W-1:0] alarm_mm;
    logic            Z;

    modport master (
        output tick_1hz, adjust, EN, up, down,
        input  time_hh, time_mm, secs, alarm_hh, alarm_mm, Z
    );

    modport slave (
        input  tick_1hz, adjust, EN, up, down,
        output time_hh, time_mm, secs, alarm_hh, alarm_mm, Z
    );

endinterface

// File: rtl/mod_field_counter.sv
// Modulo-MOD up/down counter for one clock field; wrap flags the MOD-1 -> 0 step for carry chaining.
module mod_field_counter #(
    parameter int WIDTH = 6,
    parameter int MOD   = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next value: clear wins, simultaneous inc/dec cancel, otherwise step with wrap-around.
    always_comb begin
        value_d = value_q;
        wrap    = 1'b0;
        if (clr) begin
            value_d = '0;
        end else if (inc && !dec) begin
            if (value_q == MAX_VAL) begin
                value_d = '0;
                wrap    = 1'b1;
            end else begin
                value_d = value_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (value_q == '0) value_d = MAX_VAL;
            else               value_d = value_q - 1'b1;
        end
    end

    // Field register; reset overrides any pending step.
    always_ff @(posedge clk) begin
        if (rst) value_q <= '0;
        else     value_q <= value_d;
    end

    assign value = value_q;

endmodule

// File: rtl/time_alarm_core.sv
// Time-of-day and alarm setpoint registers with run-mode counting, adjust-mode edits and alarm match.
module time_alarm_core #(
    parameter int HOURS_MOD = clock_pkg::HOURS_MOD,
    parameter int MINS_MOD  = clock_pkg::MINS_MOD,
    parameter int SECS_MOD  = clock_pkg::SECS_MOD
) (
    input  logic              clk,
    input  logic              rst,
    time_alarm_core_if.slave  bus
);
    import clock_pkg::*;

    edit_sel_e       sel;
    logic            run;
    logic            time_edit;
    logic            ss_wrap;
    logic            mm_wrap;
    logic            unused_hh_wrap;
    logic            unused_amm_wrap;
    logic            unused_ahh_wrap;
    logic            unused_en0;
    logic [MM_W-1:0] ss_val;
    logic [MM_W-1:0] mm_val;
    logic [HH_W-1:0] hh_val;
    logic [MM_W-1:0] amm_val;
    logic [HH_W-1:0] ahh_val;

    // Edits only apply in adjust mode; counting only in run mode.
    assign run        = !bus.adjust;
    assign sel        = bus.adjust ? decode_sel(bus.EN[4:1]) : SEL_NONE;
    // An accepted time edit (exactly one of up/down) restarts the seconds.
    assign time_edit  = (bus.up ^ bus.down) && ((sel == SEL_TH) || (sel == SEL_TM));
    assign unused_en0 = bus.EN[0];

    mod_field_counter #(.WIDTH(MM_W), .MOD(SECS_MOD)) u_secs (
        .clk   (clk),
        .rst   (rst),
        .inc   (run && bus.tick_1hz),
        .dec   (1'b0),
        .clr   (time_edit),
        .value (ss_val),
        .wrap  (ss_wrap)
    );

    // Carries are gated by run so a wrapping minute edit never touches the hours.
    mod_field_counter #(.WIDTH(MM_W), .MOD(MINS_MOD)) u_time_mm (
        .clk   (clk),
        .rst   (rst),
        .inc   ((run && ss_wrap) || ((sel == SEL_TM) && bus.up)),
        .dec   ((sel == SEL_TM) && bus.down),
        .clr   (1'b0),
        .value (mm_val),
        .wrap  (mm_wrap)
    );

    mod_field_counter #(.WIDTH(HH_W), .MOD(HOURS_MOD)) u_time_hh (
        .clk   (clk),
        .rst   (rst),
        .inc   ((run && mm_wrap) || ((sel == SEL_TH) && bus.up)),
        .dec   ((sel == SEL_TH) && bus.down),
        .clr   (1'b0),
        .value (hh_val),
        .wrap  (unused_hh_wrap)
    );

    mod_field_counter #(.WIDTH(MM_W), .MOD(MINS_MOD)) u_alarm_mm (
        .clk   (clk),
        .rst   (rst),
        .inc   ((sel == SEL_AM) && bus.up),
        .dec   ((sel == SEL_AM) && bus.down),
        .clr   (1'b0),
        .value (amm_val),
        .wrap  (unused_amm_wrap)
    );

    mod_field_counter #(.WIDTH(HH_W), .MOD(HOURS_MOD)) u_alarm_hh (
        .clk   (clk),
        .rst   (rst),
        .inc   ((sel == SEL_AH) && bus.up),
        .dec   ((sel == SEL_AH) && bus.down),
        .clr   (1'b0),
        .value (ahh_val),
        .wrap  (unused_ahh_wrap)
    );

    assign bus.secs     = ss_val;
    assign bus.time_mm  = mm_val;
    assign bus.time_hh  = hh_val;
    assign bus.alarm_mm = amm_val;
    assign bus.alarm_hh = ahh_val;
    // Match on hours and minutes only, straight from the registered fields.
    assign bus.Z        = (hh_val == ahh_val) && (mm_val == amm_val);

endmodule
